mem_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute ALU. Consumes its registered Signals bundle
//  and resolves conditional branches from cond + flags. Performs data-memory loads/stores over a
//  req/ack bus, with byte/half alignment, write strobes and load sign/zero extension.

---
 rtl/mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg / mem_stage
//
// Memory pipeline stage that sits directly downstream of the execute ALU.
// It takes the registered execute bundle and does three things:
//   * resolves conditional branches from cond + flags;
//   * performs data-memory loads and stores over a simple req/ack bus,
//     including byte/half alignment, write strobes and load extension;
//   * forwards a registered bundle to writeback.
// While a bus access is open, upstream is stalled.
//
// Parameters
//   TIMEOUT        ACCESS cycles to wait for mem_ack before aborting
//                  (0 = wait forever)
//   NOP_PC         pc shown on o_signals while the output bundle is invalid
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   i_signals      execute result; held stable by upstream while stall is high
//   o_signals      bundle to writeback; wdata = load data or passthrough result
//   stall          upstream must hold i_signals
//   mem_req        bus request, registered
//   mem_we         1 = store
//   mem_addr       word-aligned bus address
//   mem_wdata      store data, replicated across byte lanes
//   mem_wstrb      byte enables for stores, 0 for loads
//   mem_ack        bus completes the access this cycle; mem_rdata is valid
//   mem_rdata      load data
//   take_branch    registered branch decision
//   branch_target  registered copy of i_signals.branch
//   fault          one-cycle pulse on a misaligned access or a bus timeout
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [2:0] {
        Never    = 3'd0,
        Always   = 3'd1,
        Zero     = 3'd2,
        NotZero  = 3'd3,
        Carry    = 3'd4,
        NotCarry = 3'd5
    } cond_t;

    // The access size comes from memt for both loads and stores; the U
    // variants only change how load data is extended.
    typedef enum logic [2:0] {
        LoadByte  = 3'd0,
        LoadHalf  = 3'd1,
        LoadWord  = 3'd2,
        LoadByteU = 3'd3,
        LoadHalfU = 3'd4
    } memt_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } flags_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] wdata;   // ALU result, or the address for memory ops
        logic [31:0] reg2;    // store data
        logic        memr;
        logic        memw;
        memt_t       memt;
        cond_t       cond;
        flags_t      flags;
        logic [31:0] branch;
        logic        wback;
        logic [4:0]  wreg;
    } signals_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] NOP_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  signals_t    i_signals,
    output signals_t    o_signals,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        take_branch,
    output logic [31:0] branch_target,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state;
    signals_t    cap_q;     // memory instruction being serviced
    signals_t    out_q;     // registered output bundle
    logic [31:0] timer;     // ACCESS cycles elapsed, 0 in the first one

    logic        is_mem;
    logic        aligned;
    logic        start;
    logic        misalign;
    logic        taken;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_aligned(input memt_t t, input logic [1:0] a);
        case (t)
            LoadHalf, LoadHalfU: return ~a[0];
            LoadWord:            return (a == 2'b00);
            default:             return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] strobe_of(input memt_t t, input logic [1:0] lane);
        case (t)
            LoadHalf, LoadHalfU: return 4'b0011 << lane;
            LoadWord:            return 4'b1111;
            default:             return 4'b0001 << lane;
        endcase
    endfunction

    // The bus picks the correct lane with the strobes, so the data is simply
    // copied into every lane.
    function automatic logic [31:0] replicate(input memt_t t, input logic [31:0] d);
        case (t)
            LoadHalf, LoadHalfU: return {2{d[15:0]}};
            LoadWord:            return d;
            default:             return {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] extract(input memt_t t, input logic [1:0] lane,
                                            input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (t)
            LoadByte:  return {{24{sh[7]}}, sh[7:0]};
            LoadByteU: return {24'h0, sh[7:0]};
            LoadHalf:  return {{16{sh[15]}}, sh[15:0]};
            LoadHalfU: return {16'h0, sh[15:0]};
            default:   return rdata;
        endcase
    endfunction

    // Turns an instruction into a bubble that can never write back.
    function automatic signals_t squash(input signals_t s);
        signals_t r;
        r       = s;
        r.valid = 1'b0;
        r.wback = 1'b0;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Decode of the incoming bundle
    // ------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default value first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        is_mem   = i_signals.valid & (i_signals.memr | i_signals.memw);
        aligned  = is_aligned(i_signals.memt, i_signals.wdata[1:0]);
        start    = (state == IDLE) & is_mem & aligned;
        misalign = (state == IDLE) & is_mem & ~aligned;

        taken = 1'b0;
        case (i_signals.cond)
            Always:   taken = 1'b1;
            Zero:     taken = i_signals.flags.zero;
            NotZero:  taken = ~i_signals.flags.zero;
            Carry:    taken = i_signals.flags.carry;
            NotCarry: taken = ~i_signals.flags.carry;
            default:  taken = 1'b0;
        endcase
        taken = taken & i_signals.valid;

        load_data = extract(cap_q.memt, cap_q.wdata[1:0], mem_rdata);
    end

    // The capture cycle has to stall combinationally: the instruction is
    // still on i_signals and must stay there until ACCESS completes.
    assign stall = start | (state == ACCESS);

    // Writeback ignores pc on bubbles; showing NOP_PC makes bubbles easy to
    // spot in traces.
    always_comb begin
        o_signals = out_q;
        if (!out_q.valid) begin
            o_signals.pc = NOP_PC;
        end
    end

    // ------------------------------------------------------------------
    // Stage FSM and all registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge regardless of the
    // order of statements in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cap_q         <= '0;
            out_q         <= '0;
            timer         <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            take_branch   <= 1'b0;
            branch_target <= '0;
            fault         <= 1'b0;
        end else begin
            fault       <= 1'b0;
            take_branch <= 1'b0;

            case (state)
                IDLE: begin
                    // The branch is resolved only here, so a stalled
                    // instruction produces a single take_branch pulse.
                    take_branch   <= taken;
                    branch_target <= i_signals.branch;

                    if (start) begin
                        cap_q     <= i_signals;
                        out_q     <= squash(i_signals);
                        timer     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= i_signals.memw;
                        mem_addr  <= {i_signals.wdata[31:2], 2'b00};
                        mem_wdata <= i_signals.memw ? replicate(i_signals.memt, i_signals.reg2)
                                                    : 32'h0;
                        mem_wstrb <= i_signals.memw ? strobe_of(i_signals.memt,
                                                                i_signals.wdata[1:0])
                                                    : 4'b0000;
                        state     <= ACCESS;
                    end else if (misalign) begin
                        fault <= 1'b1;
                        out_q <= squash(i_signals);
                    end else begin
                        out_q <= i_signals;
                    end
                end

                ACCESS: begin
                    // An ack on the final allowed cycle still wins over the
                    // timeout.
                    if (mem_ack) begin
                        out_q <= cap_q;
                        if (cap_q.memw) begin
                            out_q.wback <= 1'b0;
                        end else begin
                            out_q.wdata <= load_data;
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= DONE;
                    end else if (TIMEOUT != 0 && timer == TIMEOUT_LAST) begin
                        fault     <= 1'b1;
                        out_q     <= squash(cap_q);
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                DONE: begin
                    // i_signals still holds the serviced instruction during
                    // DONE; upstream replaces it at this edge, so it is not
                    // looked at again.
                    out_q <= squash(cap_q);
                    state <= IDLE;
                end

                default: begin
                    out_q   <= squash(cap_q);
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int          TIMEOUT = 4;
    localparam logic [31:0] NOP_PC  = 32'h0000_0F00;

    logic        clk = 1'b0;
    logic        rst;
    signals_t    i_signals;
    signals_t    o_signals;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        take_branch;
    logic [31:0] branch_target;
    logic        fault;

    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    signals_t exp_q[$];
    int       out_cyc[$];
    signals_t mon_exp;

    mem_stage #(.TIMEOUT(TIMEOUT), .NOP_PC(NOP_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_signals     (i_signals),
        .o_signals     (o_signals),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid output bundle must match the oldest expectation.
    always @(negedge clk) begin
        if (o_signals.valid === 1'b1) begin
            checks++;
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got valid output pc=%h wdata=%h, required no output",
                         o_signals.pc, o_signals.wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_signals !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_bundle: got %h, required %h", o_signals, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic signals_t mk(input logic [31:0] pc, input logic [31:0] wdata,
                                    input logic [4:0] wreg);
        signals_t s;
        s       = '0;
        s.valid = 1'b1;
        s.pc    = pc;
        s.wdata = wdata;
        s.wreg  = wreg;
        s.wback = 1'b1;
        s.cond  = Never;
        s.memt  = LoadWord;
        return s;
    endfunction

    // Runs one aligned memory op end to end; ack arrives in ACCESS cycle ack_at.
    task automatic do_mem(input signals_t s, input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic [31:0] exp_addr,
                          input logic [31:0] exp_bus_wdata, input logic [3:0] exp_strb,
                          input logic exp_taken);
        signals_t e;
        int       req_cycles;
        e = s;
        if (s.memr) e.wdata = exp_data;
        if (s.memw) e.wback = 1'b0;
        exp_q.push_back(e);

        i_signals = s;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mem_capture_stall: got %b, required 1", stall);
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
            {1'b1, s.memw, exp_addr, exp_bus_wdata, exp_strb}) begin
            errors++;
            $display("FAIL mem_bus: got req=%b we=%b addr=%h wdata=%h wstrb=%b, required req=1 we=%b addr=%h wdata=%h wstrb=%b",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                     s.memw, exp_addr, exp_bus_wdata, exp_strb);
        end
        checks++;
        if ({take_branch, o_signals.valid} !== {exp_taken, 1'b0}) begin
            errors++;
            $display("FAIL mem_access_entry: got take_branch=%b valid=%b, required %b 0",
                     take_branch, o_signals.valid, exp_taken);
        end
        req_cycles = 0;
        for (int c = 1; c <= ack_at; c++) begin
            if (mem_req === 1'b1 && stall === 1'b1) req_cycles++;
            if (c == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = ~rdata;
            end
            tick();
            mem_ack = 1'b0;
        end
        checks++;
        if (req_cycles !== ack_at) begin
            errors++;
            $display("FAIL mem_req_cycles: got %0d, required %0d", req_cycles, ack_at);
        end
        checks++;
        if ({mem_req, stall, take_branch, o_signals.valid, o_signals.wdata} !==
            {1'b0, 1'b0, 1'b0, 1'b1, e.wdata}) begin
            errors++;
            $display("FAIL mem_done: got req=%b stall=%b tb=%b valid=%b wdata=%h, required 0 0 0 1 %h",
                     mem_req, stall, take_branch, o_signals.valid, o_signals.wdata, e.wdata);
        end
        tick();
        i_signals = '0;
    endtask

    task automatic test_reset();
        signals_t e;
        rst       = 1'b1;
        i_signals = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        e      = '0;
        e.pc   = NOP_PC;
        e.cond = Never;
        e.memt = LoadByte;
        checks++;
        if (o_signals !== e) begin
            errors++;
            $display("FAIL reset_bundle: got %h, required %h", o_signals, e);
        end
        checks++;
        if ({stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             take_branch, branch_target, fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h wstrb=%b tb=%b tgt=%h fault=%b, required all 0",
                     stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                     take_branch, branch_target, fault);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        signals_t s;
        for (int i = 0; i < 4; i++) begin
            s = mk(32'h1000 + 32'(4 * i), (i == 0) ? 32'h1234 : $urandom, 5'(i + 1));
            exp_q.push_back(s);
            i_signals = s;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL alu_stall: got %b, required 0", stall);
            end
            tick();
            checks++;
            if (o_signals.wdata !== s.wdata || o_signals.valid !== 1'b1) begin
                errors++;
                $display("FAIL alu_passthrough: got valid=%b wdata=%h, required 1 %h",
                         o_signals.valid, o_signals.wdata, s.wdata);
            end
        end
        i_signals = '0;
        tick();
    endtask

    task automatic test_loads();
        logic [31:0] addr  [6] = '{32'h103, 32'h202, 32'h200, 32'h101, 32'h100, 32'h300};
        memt_t       typ   [6] = '{LoadByte, LoadHalf, LoadHalfU, LoadByteU, LoadByte, LoadWord};
        logic [31:0] rdata [6] = '{32'h8012_3456, 32'h8001_5555, 32'h1234_F00D,
                                   32'h0000_9A00, 32'hFFFF_FF7F, 32'hCAFE_BABE};
        logic [31:0] exp   [6] = '{32'hFFFF_FF80, 32'hFFFF_8001, 32'h0000_F00D,
                                   32'h0000_009A, 32'h0000_007F, 32'hCAFE_BABE};
        int          ack   [6] = '{2, 1, 3, 1, 2, 4};
        signals_t    s;
        for (int i = 0; i < 6; i++) begin
            s      = mk(32'h2000 + 32'(4 * i), addr[i], 5'(10 + i));
            s.memr = 1'b1;
            s.memt = typ[i];
            do_mem(s, ack[i], rdata[i], exp[i], {addr[i][31:2], 2'b00}, 32'h0, 4'b0000, 1'b0);
        end
    endtask

    task automatic test_stores();
        logic [31:0] addr [4] = '{32'h102, 32'h106, 32'h108, 32'h10B};
        memt_t       typ  [4] = '{LoadByte, LoadHalf, LoadWord, LoadByte};
        logic [31:0] reg2 [4] = '{32'h1122_33AB, 32'hAAAA_1234, 32'hDEAD_BEEF, 32'h0000_005C};
        logic [31:0] bus  [4] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF, 32'h5C5C_5C5C};
        logic [3:0]  strb [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b1000};
        signals_t    s;
        for (int i = 0; i < 4; i++) begin
            s        = mk(32'h3000 + 32'(4 * i), addr[i], 5'(20 + i));
            s.memw   = 1'b1;
            s.memt   = typ[i];
            s.reg2   = reg2[i];
            s.cond   = (i == 1) ? Always : Never;
            s.branch = 32'h0000_0800;
            do_mem(s, 1 + (i % 2), 32'h0, 32'h0, {addr[i][31:2], 2'b00}, bus[i], strb[i], i == 1);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addr [3] = '{32'h102, 32'h101, 32'h103};
        memt_t       typ  [3] = '{LoadWord, LoadHalfU, LoadHalf};
        signals_t    s;
        for (int i = 0; i < 3; i++) begin
            s      = mk(32'h4000 + 32'(4 * i), addr[i], 5'd7);
            s.memt = typ[i];
            s.memr = (i != 2);
            s.memw = (i == 2);
            i_signals = s;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL misalign_stall: got %b, required 0", stall);
            end
            tick();
            checks++;
            if ({fault, mem_req, o_signals.valid, o_signals.wback, o_signals.pc} !==
                {1'b1, 1'b0, 1'b0, 1'b0, NOP_PC}) begin
                errors++;
                $display("FAIL misalign_fault: got fault=%b req=%b valid=%b wback=%b pc=%h, required 1 0 0 0 %h",
                         fault, mem_req, o_signals.valid, o_signals.wback, o_signals.pc, NOP_PC);
            end
            i_signals = '0;
            tick();
            checks++;
            if ({fault, mem_req} !== 2'b00) begin
                errors++;
                $display("FAIL misalign_pulse: got fault=%b req=%b, required 0 0", fault, mem_req);
            end
        end
    endtask

    task automatic test_branch();
        cond_t    cnd [10] = '{Zero, Zero, NotZero, NotZero, Carry, NotCarry, NotCarry,
                               Always, Never, Always};
        logic     z   [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        logic     c   [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
        logic     v   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic     exp [10] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
        signals_t s;
        for (int i = 0; i < 10; i++) begin
            s             = mk(32'h5000 + 32'(4 * i), 32'h0000_0055 + 32'(i), 5'd3);
            s.cond        = cnd[i];
            s.flags.zero  = z[i];
            s.flags.carry = c[i];
            s.branch      = 32'h40 + 32'(16 * i);
            s.valid       = v[i];
            if (v[i]) exp_q.push_back(s);
            i_signals = s;
            tick();
            checks++;
            if ({take_branch, branch_target} !== {exp[i], s.branch}) begin
                errors++;
                $display("FAIL branch_%0d: got take=%b target=%h, required %b %h",
                         i, take_branch, branch_target, exp[i], s.branch);
            end
        end
        i_signals = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        signals_t s;
        out_cyc.delete();
        s      = mk(32'h6000, 32'h0000_0600, 5'd1);
        s.memr = 1'b1;
        do_mem(s, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h600, 32'h0, 4'b0000, 1'b0);
        s      = mk(32'h6004, 32'h0000_0604, 5'd2);
        s.memw = 1'b1;
        s.reg2 = 32'h7777_8888;
        do_mem(s, 1, 32'h0, 32'h0, 32'h604, 32'h7777_8888, 4'b1111, 1'b0);
        s = mk(32'h6008, 32'h0000_4321, 5'd3);
        exp_q.push_back(s);
        i_signals = s;
        tick();
        i_signals = '0;
        tick();
        checks++;
        if (out_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs, required 3", out_cyc.size());
        end else begin
            checks++;
            if (out_cyc[1] - out_cyc[0] != 3 || out_cyc[2] - out_cyc[1] != 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d %0d cycles, required 3 2",
                         out_cyc[1] - out_cyc[0], out_cyc[2] - out_cyc[1]);
            end
        end
    endtask

    task automatic test_timeout();
        signals_t s;
        int       req_cycles;
        s      = mk(32'h7000, 32'h0000_0400, 5'd9);
        s.memr = 1'b1;
        i_signals = s;
        tick();
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        i_signals = '0;
        checks++;
        if (req_cycles !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, required %0d", req_cycles, TIMEOUT);
        end
        checks++;
        if ({fault, o_signals.valid, stall} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_fault: got fault=%b valid=%b stall=%b, required 1 0 0",
                     fault, o_signals.valid, stall);
        end
        tick();
        checks++;
        if ({fault, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got fault=%b req=%b, required 0 0", fault, mem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        signals_t s;
        s      = mk(32'h8000, 32'h0000_0500, 5'd4);
        s.memr = 1'b1;
        i_signals = s;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%b, required 1", mem_req);
        end
        rst       = 1'b1;
        i_signals = '0;
        tick();
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_drop: got req=%b stall=%b, required 0 0", mem_req, stall);
        end
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if ({mem_req, stall, o_signals.valid, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ack_ignored: got req=%b stall=%b valid=%b fault=%b, required 0 0 0 0",
                     mem_req, stall, o_signals.valid, fault);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misaligned();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outputs missing, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
